tl_tx_err_msg_sender: RTL and testbench

TL_TX_ERR_MSG_SENDER -- requirements
Module: tl_tx_err_msg_sender

---
 rtl/tl_tx_err_msg_sender_pkg.sv | 26 ++
 rtl/tl_tx_ur_cpl_hdr_builder.sv | 22 ++
 rtl/tl_tx_err_msg_sender.sv | 124 ++++++++++++
 tb/tb_tl_tx_err_msg_sender.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_tx_err_msg_sender_pkg.sv
// Shared constants for the RX-error message sender: FSM encoding, Cpl header fields,
// PCIe error message codes and the DW1 field positions inside the 128-bit error header.
package tl_tx_err_msg_sender_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND_MSG,
      SEND_CPL,
      POP
   } state_t;

   localparam logic [7:0]  CPL_FMT_TYPE = 8'h0A;
   localparam logic [2:0]  CPL_STS_UR   = 3'b001;
   localparam logic [11:0] UR_BYTE_CNT  = 12'd4;

   localparam logic [7:0]  MSG_ERR_COR      = 8'h30;
   localparam logic [7:0]  MSG_ERR_NONFATAL = 8'h31;
   localparam logic [7:0]  MSG_ERR_FATAL    = 8'h33;

   // Message code, requester ID and tag all live in DW1 (bits [95:64]) of {DW0,DW1,DW2,DW3}.
   localparam int MSG_CODE_LSB = 64;
   localparam int TAG_LSB      = 72;
   localparam int REQ_ID_LSB   = 80;

endpackage

// File: rtl/tl_tx_ur_cpl_hdr_builder.sv
// Combinational 3DW Unsupported-Request completion header: {DW0, DW1, DW2, DW3=0}.
module tl_tx_ur_cpl_hdr_builder
   import tl_tx_err_msg_sender_pkg::*;
#(
   parameter int COMPLETER_ID_W = 16
) (
   input  logic [COMPLETER_ID_W-1:0] completer_id,
   input  logic [15:0]               req_id,
   input  logic [7:0]                tag,
   output logic [127:0]              cpl_hdr
);

   logic [15:0] cid;
   assign cid = 16'(completer_id);

   // Length 0, BCM 0, lower address 0.
   assign cpl_hdr = {CPL_FMT_TYPE, 24'h0,
                     cid, CPL_STS_UR, 1'b0, UR_BYTE_CNT,
                     req_id, tag, 1'b0, 7'd0,
                     32'h0};

endmodule

// File: rtl/tl_tx_err_msg_sender.sv
// Drains the RX error FIFO: forwards each error message to TX and, when the build defines
// TL_TX_ERR_UR_CPL_EN, follows it with a UR completion; pops the entry once all TLPs are accepted.
module tl_tx_err_msg_sender
   import tl_tx_err_msg_sender_pkg::*;
#(
   parameter int COMPLETER_ID_W = 16,
   parameter int CNT_W          = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      err_fifo_empty,
   input  logic [127:0]              err_tlp_msg,
   input  logic                      err_ur_cpl_valid,
   input  logic [COMPLETER_ID_W-1:0] completer_id,
   output logic                      msg_trans_en,
   output logic                      read_ptr_incr,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [127:0]              tx_hdr,
   output logic                      tx_hdr_4dw,
   output logic [CNT_W-1:0]          msg_sent_cnt
);

   state_t       state;
   logic [127:0] msg_q;
   logic         cpl_q;
   logic         ur_in;
   logic [127:0] cpl_hdr;

`ifdef TL_TX_ERR_UR_CPL_EN
   logic [23:0] cpl_src;

   // In LOAD the header comes straight from the FIFO since msg_q is only captured at the edge.
   assign cpl_src = (state == LOAD) ? err_tlp_msg[TAG_LSB +: 24] : msg_q[TAG_LSB +: 24];
   assign ur_in   = err_ur_cpl_valid;

   tl_tx_ur_cpl_hdr_builder #(
      .COMPLETER_ID_W (COMPLETER_ID_W)
   ) u_cpl_hdr (
      .completer_id (completer_id),
      .req_id       (cpl_src[23:8]),
      .tag          (cpl_src[7:0]),
      .cpl_hdr      (cpl_hdr)
   );
`else
   logic unused_cpl_cfg;

   assign unused_cpl_cfg = ^{completer_id, err_ur_cpl_valid};
   assign ur_in          = 1'b0;
   assign cpl_hdr        = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         msg_q         <= '0;
         cpl_q         <= 1'b0;
         msg_sent_cnt  <= '0;
         tx_valid      <= 1'b0;
         tx_hdr        <= '0;
         tx_hdr_4dw    <= 1'b0;
         msg_trans_en  <= 1'b0;
         read_ptr_incr <= 1'b0;
      end else begin
         msg_trans_en  <= 1'b0;
         read_ptr_incr <= 1'b0;
         case (state)
            IDLE: begin
               if (!err_fifo_empty) begin
                  state        <= LOAD;
                  msg_trans_en <= 1'b1;
               end
            end
            LOAD: begin
               msg_q <= err_tlp_msg;
               cpl_q <= ur_in;
               if (err_tlp_msg[MSG_CODE_LSB +: 8] != 8'h00) begin
                  state      <= SEND_MSG;
                  tx_valid   <= 1'b1;
                  tx_hdr     <= err_tlp_msg;
                  tx_hdr_4dw <= 1'b1;
               end else if (ur_in) begin
                  state      <= SEND_CPL;
                  tx_valid   <= 1'b1;
                  tx_hdr     <= cpl_hdr;
                  tx_hdr_4dw <= 1'b0;
               end else begin
                  state         <= POP;
                  read_ptr_incr <= 1'b1;
               end
            end
            SEND_MSG: begin
               if (tx_ready) begin
                  if (msg_sent_cnt != {CNT_W{1'b1}})
                     msg_sent_cnt <= msg_sent_cnt + CNT_W'(1);
                  if (cpl_q) begin
                     state      <= SEND_CPL;
                     tx_hdr     <= cpl_hdr;
                     tx_hdr_4dw <= 1'b0;
                  end else begin
                     state         <= POP;
                     tx_valid      <= 1'b0;
                     tx_hdr        <= '0;
                     tx_hdr_4dw    <= 1'b0;
                     read_ptr_incr <= 1'b1;
                  end
               end
            end
            SEND_CPL: begin
               if (tx_ready) begin
                  state         <= POP;
                  tx_valid      <= 1'b0;
                  tx_hdr        <= '0;
                  tx_hdr_4dw    <= 1'b0;
                  read_ptr_incr <= 1'b1;
               end
            end
            POP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tl_tx_err_msg_sender.sv
// Directed bench for tl_tx_err_msg_sender: vector table plus backpressure, reset and
// back-to-back sequences. Expectations follow TL_TX_ERR_UR_CPL_EN as seen by the compile.
module tb_tl_tx_err_msg_sender;

`ifdef TL_TX_ERR_UR_CPL_EN
   localparam bit CPL_EN = 1'b1;
`else
   localparam bit CPL_EN = 1'b0;
`endif
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           err_fifo_empty = 1'b1;
   logic [127:0]   err_tlp_msg = '0;
   logic           err_ur_cpl_valid = 1'b0;
   logic [15:0]    completer_id = 16'h0100;
   logic           msg_trans_en, read_ptr_incr, tx_valid, tx_hdr_4dw;
   logic           tx_ready = 1'b1;
   logic [127:0]   tx_hdr;
   logic [CW-1:0]  msg_sent_cnt;

   tl_tx_err_msg_sender #(.COMPLETER_ID_W(16), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .err_fifo_empty   (err_fifo_empty),
      .err_tlp_msg      (err_tlp_msg),
      .err_ur_cpl_valid (err_ur_cpl_valid),
      .completer_id     (completer_id),
      .msg_trans_en     (msg_trans_en),
      .read_ptr_incr    (read_ptr_incr),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .tx_hdr           (tx_hdr),
      .tx_hdr_4dw       (tx_hdr_4dw),
      .msg_sent_cnt     (msg_sent_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] msg;
      logic         ur;
      logic [15:0]  cid;
      logic         has_msg;
      logic         has_cpl;
      logic [127:0] cpl;
   } vec_t;

   vec_t         vecs [6];
   int           fifo [$];
   logic [127:0] acc_hdr [$];
   logic         acc_4dw [$];
   int           pop_cyc [$];
   int           total = 0, bad = 0;
   int           cyc = 0, pop_cnt = 0, ld_cnt = 0;
   logic         pv = 1'b0;
   logic [127:0] ph = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive_head();
      if (fifo.size() == 0) begin
         err_fifo_empty   = 1'b1;
         err_tlp_msg      = '0;
         err_ur_cpl_valid = 1'b0;
      end else begin
         err_fifo_empty   = 1'b0;
         err_tlp_msg      = vecs[fifo[0]].msg;
         err_ur_cpl_valid = vecs[fifo[0]].ur;
         completer_id     = vecs[fifo[0]].cid;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pop(input int target, input int lim);
      for (int k = 0; k < lim && pop_cnt < target; k++) step();
      chk("pop_wait", 128'(pop_cnt >= target), 128'(1));
   endtask

   // FIFO model and protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         pv = 1'b0;
      end else begin
         if (!tx_valid && tx_hdr != '0) chk("hdr_zero_idle", tx_hdr, '0);
         if (pv) begin
            chk("hold_valid", 128'(tx_valid), 128'(1));
            chk("hold_hdr", tx_hdr, ph);
         end
         pv = tx_valid && !tx_ready;
         ph = tx_hdr;
         if (tx_valid && tx_ready) begin
            acc_hdr.push_back(tx_hdr);
            acc_4dw.push_back(tx_hdr_4dw);
         end
         if (msg_trans_en) ld_cnt++;
         if (read_ptr_incr) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if (fifo.size() > 0) void'(fifo.pop_front());
            drive_head();
         end
      end
   end

   int exp_cnt = 0;

   function automatic int sat_inc(input int v);
      return (v == (1 << CW) - 1) ? v : v + 1;
   endfunction

   task automatic check_acc(input string name, input int vi);
      logic [127:0] eh [$];
      logic         e4 [$];
      if (vecs[vi].has_msg) begin eh.push_back(vecs[vi].msg); e4.push_back(1'b1); end
      if (vecs[vi].has_cpl && CPL_EN) begin eh.push_back(vecs[vi].cpl); e4.push_back(1'b0); end
      chk({name, "_ntlp"}, 128'(acc_hdr.size()), 128'(eh.size()));
      for (int k = 0; k < eh.size() && k < acc_hdr.size(); k++) begin
         chk({name, "_hdr"}, acc_hdr[k], eh[k]);
         chk({name, "_4dw"}, 128'(acc_4dw[k]), 128'(e4[k]));
      end
   endtask

   initial begin
      int p0, l0, c0;
      vecs[0] = '{128'h3000_0000_ABCD_5A31_0000_0000_0000_0000, 1'b0, 16'h0100, 1'b1, 1'b0, '0};
      vecs[1] = '{128'h3000_0000_1234_7730_0000_0000_0000_0000, 1'b1, 16'h0100, 1'b1, 1'b1,
                  128'h0A00_0000_0100_2004_1234_7700_0000_0000};
      vecs[2] = '{128'h3000_0000_5678_9A00_0000_0000_0000_0000, 1'b1, 16'h0100, 1'b0, 1'b1,
                  128'h0A00_0000_0100_2004_5678_9A00_0000_0000};
      vecs[3] = '{128'h3400_0000_BEEF_0133_DEAD_BEEF_0000_0000, 1'b0, 16'h0100, 1'b1, 1'b0, '0};
      vecs[4] = '{128'h3000_0000_1111_2200_0000_0000_0000_0000, 1'b0, 16'h0100, 1'b0, 1'b0, '0};
      vecs[5] = '{128'h3000_0000_0A0B_C330_0000_0000_0000_0000, 1'b1, 16'hFF08, 1'b1, 1'b1,
                  128'h0A00_0000_FF08_2004_0A0B_C300_0000_0000};

      // Reset state
      repeat (3) step();
      chk("rst_trans_en", 128'(msg_trans_en), '0);
      chk("rst_pop", 128'(read_ptr_incr), '0);
      chk("rst_valid", 128'(tx_valid), '0);
      chk("rst_hdr", tx_hdr, '0);
      chk("rst_4dw", 128'(tx_hdr_4dw), '0);
      chk("rst_cnt", 128'(msg_sent_cnt), '0);
      rst = 1'b1;
      step();

      // Table-driven single entries
      for (int i = 0; i < 6; i++) begin
         acc_hdr.delete(); acc_4dw.delete();
         p0 = pop_cnt; l0 = ld_cnt;
         fifo.push_back(i);
         drive_head();
         wait_pop(p0 + 1, 40);
         repeat (3) step();
         check_acc($sformatf("vec%0d", i), i);
         chk($sformatf("vec%0d_pops", i), 128'(pop_cnt - p0), 128'(1));
         chk($sformatf("vec%0d_loads", i), 128'(ld_cnt - l0), 128'(1));
         if (vecs[i].has_msg) exp_cnt = sat_inc(exp_cnt);
         chk($sformatf("vec%0d_cnt", i), 128'(msg_sent_cnt), 128'(exp_cnt));
      end

      // Backpressure: 10 stalled cycles, header held, no pop
      tx_ready = 1'b0;
      p0 = pop_cnt;
      fifo.push_back(0);
      drive_head();
      for (int k = 0; k < 10 && !tx_valid; k++) step();
      chk("bp_valid_seen", 128'(tx_valid), 128'(1));
      for (int k = 0; k < 10; k++) begin
         step();
         if (tx_valid !== 1'b1 || tx_hdr !== vecs[0].msg || pop_cnt != p0) begin
            chk("bp_stall_valid", 128'(tx_valid), 128'(1));
            chk("bp_stall_hdr", tx_hdr, vecs[0].msg);
            chk("bp_stall_nopop", 128'(pop_cnt), 128'(p0));
         end
      end
      chk("bp_stall_hdr_end", tx_hdr, vecs[0].msg);
      chk("bp_nopop", 128'(pop_cnt), 128'(p0));
      tx_ready = 1'b1;
      wait_pop(p0 + 1, 20);
      exp_cnt = sat_inc(exp_cnt);
      chk("bp_cnt", 128'(msg_sent_cnt), 128'(exp_cnt));

      // Reset in the completion phase (message phase when completions are disabled)
      tx_ready = 1'b0;
      p0 = pop_cnt;
      fifo.push_back(1);
      drive_head();
      for (int k = 0; k < 10 && !tx_valid; k++) step();
      if (CPL_EN) begin
         tx_ready = 1'b1;
         step();
         tx_ready = 1'b0;
         chk("rstmid_in_cpl", {tx_valid, tx_hdr_4dw, tx_hdr}, {2'b10, vecs[1].cpl});
      end
      rst = 1'b0;
      #1;
      chk("rstmid_outs", {msg_trans_en, read_ptr_incr, tx_valid, tx_hdr_4dw, tx_hdr}, '0);
      chk("rstmid_cnt", 128'(msg_sent_cnt), '0);
      step(); step();
      chk("rstmid_nopop", 128'(pop_cnt), 128'(p0));
      exp_cnt = 0;
      rst = 1'b1;
      acc_hdr.delete(); acc_4dw.delete();
      tx_ready = 1'b1;
      wait_pop(p0 + 1, 40);
      check_acc("rstmid_resend", 1);
      exp_cnt = sat_inc(exp_cnt);
      chk("rstmid_cnt_after", 128'(msg_sent_cnt), 128'(exp_cnt));

      // Back-to-back: three queued entries, pops every 4 cycles
      step();
      pop_cyc.delete();
      p0 = pop_cnt;
      for (int k = 0; k < 3; k++) fifo.push_back(0);
      drive_head();
      wait_pop(p0 + 3, 60);
      if (pop_cyc.size() >= 3) begin
         chk("b2b_gap1", 128'(pop_cyc[1] - pop_cyc[0]), 128'(4));
         chk("b2b_gap2", 128'(pop_cyc[2] - pop_cyc[1]), 128'(4));
      end
      for (int k = 0; k < 3; k++) exp_cnt = sat_inc(exp_cnt);
      step();
      chk("b2b_cnt", 128'(msg_sent_cnt), 128'(exp_cnt));

      // Drive the counter into saturation, then past it
      p0 = pop_cnt;
      for (int k = 0; k < 12; k++) fifo.push_back(3);
      drive_head();
      wait_pop(p0 + 12, 200);
      for (int k = 0; k < 12; k++) exp_cnt = sat_inc(exp_cnt);
      step();
      chk("sat_reach", 128'(msg_sent_cnt), 128'({CW{1'b1}}));
      c0 = pop_cnt;
      for (int k = 0; k < 3; k++) fifo.push_back(0);
      drive_head();
      wait_pop(c0 + 3, 60);
      step();
      chk("sat_hold", 128'(msg_sent_cnt), 128'({CW{1'b1}}));
      chk("sat_model", 128'(msg_sent_cnt), 128'(exp_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
